text_overlay_sched: RTL and testbench

Character scheduler for the two HUD text rows drawn at the right of the 800x600 @ 60 Hz screen (40 MHz pixel clock). The block tracks the beam position and emits, one cycle later, the character code, font row and pixel column for the shared 8x16 font ROM. Row 1 shows "SCORE dddd"; row 2 shows "LIVES" followed by heart glyphs. Once per frame, during vertical blanking, it converts the binary score to BCD with a multi-cycle double-dabble sequence, so the displayed digits never tear mid-frame.

---
 rtl/text_overlay_sched.sv | 203 ++++++++++++++++++++
 tb/tb_text_overlay_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_overlay_sched.sv
// HUD text-row character scheduler with a once-per-frame score-to-BCD conversion.
// Optional feature: define TEXT_BLINK_EN to blink row 2 while one life remains.
module text_overlay_sched #(
  parameter int unsigned RECT_X      = 576,
  parameter int unsigned RECT_Y      = 268,
  parameter int unsigned RECT_Y_2    = 332,
  parameter int unsigned RECT_CHAR_X = 128,
  parameter int unsigned RECT_CHAR_Y = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        vblnk,
  input  logic [13:0] score,
  input  logic [2:0]  lives,
  output logic [6:0]  char_code,
  output logic [3:0]  char_line,
  output logic [2:0]  char_col,
  output logic        char_act,
  output logic        conv_busy
);

  localparam int unsigned POS_W   = 11;
  localparam int unsigned SCORE_W = 14;
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned WORK_W  = BCD_W + SCORE_W;
  localparam int unsigned ITERS   = 14;
  localparam int unsigned ITER_W  = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(9999);

  localparam logic [6:0] CH_SPC   = 7'h20;
  localparam logic [6:0] CH_ZERO  = 7'h30;
  localparam logic [6:0] CH_HEART = 7'h03;
  localparam logic [6:0] CH_S     = 7'h53;
  localparam logic [6:0] CH_C     = 7'h43;
  localparam logic [6:0] CH_O     = 7'h4F;
  localparam logic [6:0] CH_R     = 7'h52;
  localparam logic [6:0] CH_E     = 7'h45;
  localparam logic [6:0] CH_L     = 7'h4C;
  localparam logic [6:0] CH_I     = 7'h49;
  localparam logic [6:0] CH_V     = 7'h56;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state;
  logic                vblnk_q;
  logic [WORK_W-1:0]   work;       // {bcd accumulator, score_q shift register}
  logic [WORK_W-1:0]   work_step_c;
  logic [ITER_W-1:0]   iter;
  logic [BCD_W-1:0]    disp_bcd;
  logic [2:0]          lives_q;
  logic                vblnk_rise_c;
  logic                blank_r2_c;

  assign vblnk_rise_c = vblnk && !vblnk_q;

  // Beam geometry
  logic [POS_W:0] h_ext, v_ext;
  logic           in_h_c, in_r1_c, in_r2_c;
  logic [6:0]     h_rel_c;
  logic [3:0]     idx_c, v_rel1_c, v_rel2_c;

  assign h_ext    = {1'b0, hcount};
  assign v_ext    = {1'b0, vcount};
  assign in_h_c   = (h_ext >= 12'(RECT_X)) && (h_ext < 12'(RECT_X + RECT_CHAR_X));
  assign in_r1_c  = in_h_c && (v_ext >= 12'(RECT_Y)) && (v_ext < 12'(RECT_Y + RECT_CHAR_Y));
  assign in_r2_c  = in_h_c && (v_ext >= 12'(RECT_Y_2)) && (v_ext < 12'(RECT_Y_2 + RECT_CHAR_Y));
  assign h_rel_c  = 7'(hcount - 11'(RECT_X));
  assign idx_c    = h_rel_c[6:3];
  assign v_rel1_c = 4'(vcount - 11'(RECT_Y));
  assign v_rel2_c = 4'(vcount - 11'(RECT_Y_2));

`ifdef TEXT_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            frame_cnt <= '0;
    else if (vblnk_rise_c) frame_cnt <= frame_cnt + 6'd1;
  end

  assign blank_r2_c = (lives_q == 3'd1) && frame_cnt[5];
`else
  assign blank_r2_c = 1'b0;
`endif

  // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift the pair left
  always_comb begin
    work_step_c = work;
    for (int i = 0; i < 4; i++) begin
      if (work[SCORE_W + 4*i +: 4] >= 4'd5)
        work_step_c[SCORE_W + 4*i +: 4] = work[SCORE_W + 4*i +: 4] + 4'd3;
    end
    work_step_c = work_step_c << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vblnk_q   <= 1'b0;
      work      <= '0;
      iter      <= '0;
      disp_bcd  <= '0;
      lives_q   <= '0;
      conv_busy <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      case (state)
        IDLE: begin
          if (vblnk_rise_c) begin
            work      <= {BCD_W'(0), (score > SCORE_MAX) ? SCORE_MAX : score};
            lives_q   <= lives;
            iter      <= '0;
            conv_busy <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          work <= work_step_c;
          iter <= iter + ITER_W'(1);
          if (iter == ITER_W'(ITERS - 1)) state <= COMMIT;
        end
        COMMIT: begin
          disp_bcd  <= work[WORK_W-1:SCORE_W];
          conv_busy <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          conv_busy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Character decode for the current beam position
  logic [6:0] code_c;
  logic [3:0] line_c;
  logic [2:0] col_c;
  logic       act_c;

  always_comb begin
    code_c = CH_SPC;
    line_c = '0;
    col_c  = '0;
    act_c  = 1'b0;
    if (in_r1_c) begin
      act_c  = 1'b1;
      line_c = v_rel1_c;
      col_c  = h_rel_c[2:0];
      case (idx_c)
        4'd0:    code_c = CH_S;
        4'd1:    code_c = CH_C;
        4'd2:    code_c = CH_O;
        4'd3:    code_c = CH_R;
        4'd4:    code_c = CH_E;
        4'd6:    code_c = CH_ZERO + {3'b000, disp_bcd[15:12]};
        4'd7:    code_c = CH_ZERO + {3'b000, disp_bcd[11:8]};
        4'd8:    code_c = CH_ZERO + {3'b000, disp_bcd[7:4]};
        4'd9:    code_c = CH_ZERO + {3'b000, disp_bcd[3:0]};
        default: code_c = CH_SPC;
      endcase
    end else if (in_r2_c) begin
      act_c  = 1'b1;
      line_c = v_rel2_c;
      col_c  = h_rel_c[2:0];
      case (idx_c)
        4'd0:    code_c = CH_L;
        4'd1:    code_c = CH_I;
        4'd2:    code_c = CH_V;
        4'd3:    code_c = CH_E;
        4'd4:    code_c = CH_S;
        default: begin
          if ((idx_c >= 4'd6) && (idx_c <= 4'd12) && ((idx_c - 4'd6) < {1'b0, lives_q}))
            code_c = CH_HEART;
          else
            code_c = CH_SPC;
        end
      endcase
      if (blank_r2_c) code_c = CH_SPC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code <= '0;
      char_line <= '0;
      char_col  <= '0;
      char_act  <= 1'b0;
    end else begin
      char_code <= code_c;
      char_line <= line_c;
      char_col  <= col_c;
      char_act  <= act_c;
    end
  end

endmodule

// File: tb/tb_text_overlay_sched.sv
// Self-checking bench for text_overlay_sched: boundary table, corner sequences, random frames.
`timescale 1ns/1ps
module tb_text_overlay_sched;

  localparam int RX  = 576;
  localparam int RY  = 268;
  localparam int RY2 = 332;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic        vblnk = 1'b0;
  logic [13:0] score = '0;
  logic [2:0]  lives = '0;
  logic [6:0]  char_code;
  logic [3:0]  char_line;
  logic [2:0]  char_col;
  logic        char_act;
  logic        conv_busy;

  text_overlay_sched dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .vblnk(vblnk),
    .score(score), .lives(lives), .char_code(char_code), .char_line(char_line),
    .char_col(char_col), .char_act(char_act), .conv_busy(conv_busy)
  );

  always #12.5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_score = 0;
  int m_lives = 0;
  int m_frames = 0;

  typedef struct {
    int         h;
    int         v;
    logic [6:0] code;
    logic [3:0] line;
    logic [2:0] col;
    logic       act;
  } vec_t;

  // Reference: the rows are text strings; packed result is {act, code, line, col}
  function automatic logic [14:0] model(int h, int v);
    int    row, top, idx;
    string s;
    logic [6:0] code;
    bit    blank;
    row = 0;
    top = 0;
    if (h >= RX && h < RX + 128) begin
      if (v >= RY && v < RY + 16) begin row = 1; top = RY; end
      else if (v >= RY2 && v < RY2 + 16) begin row = 2; top = RY2; end
    end
    if (row == 0) return {1'b0, 7'h20, 4'd0, 3'd0};
    idx = (h - RX) / 8;
    if (row == 1) begin
      s = $sformatf("SCORE %04d      ", m_score);
      code = 7'(s.getc(idx));
    end else begin
      s = "LIVES           ";
      if (idx >= 6 && idx <= 12 && (idx - 6) < m_lives) code = 7'h03;
      else code = 7'(s.getc(idx));
`ifdef TEXT_BLINK_EN
      blank = (m_lives == 1) && ((m_frames % 64) >= 32);
`else
      blank = 1'b0;
`endif
      if (blank) code = 7'h20;
    end
    return {1'b1, code, 4'(v - top), 3'((h - RX) % 8)};
  endfunction

  task automatic check_out(string name, logic [14:0] exp);
    checks++;
    if ({char_act, char_code, char_line, char_col} !== exp) begin
      failures++;
      $display("FAIL %s: got act=%0b code=%h line=%0d col=%0d, want act=%0b code=%h line=%0d col=%0d",
               name, char_act, char_code, char_line, char_col,
               exp[14], exp[13:7], exp[6:3], exp[2:0]);
    end
  endtask

  task automatic check_val(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(int h, int v);
    hcount = 11'(h);
    vcount = 11'(v);
    step();
  endtask

  // Raise vblnk once and count contiguous busy cycles (bounded)
  task automatic do_frame(int s, int l, output int busy_cycles);
    bit seen;
    vblnk = 1'b0;
    score = 14'(s);
    lives = 3'(l);
    step();
    vblnk = 1'b1;
    m_frames++;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (conv_busy) begin busy_cycles++; seen = 1'b1; end
      else if (seen) break;
    end
    vblnk = 1'b0;
    m_score = (s > 9999) ? 9999 : s;
    m_lives = l;
  endtask

  task automatic scan_rows(string tag);
    for (int i = 0; i < 16; i++) begin
      probe(RX + 8*i + (i % 8), RY + 5);
      check_out($sformatf("%s_r1_idx%0d", tag, i), model(RX + 8*i + (i % 8), RY + 5));
      probe(RX + 8*i, RY2 + (i % 16));
      check_out($sformatf("%s_r2_idx%0d", tag, i), model(RX + 8*i, RY2 + (i % 16)));
    end
  endtask

  initial begin
    vec_t tab[$];
    int   bc, h, v;
    bit   seen;

    // Boundary vectors, valid once score=1234 and lives=3 are displayed
    tab.push_back('{575, 268, 7'h20, 4'd0,  3'd0, 1'b0});
    tab.push_back('{576, 268, 7'h53, 4'd0,  3'd0, 1'b1});
    tab.push_back('{703, 268, 7'h20, 4'd0,  3'd7, 1'b1});
    tab.push_back('{704, 268, 7'h20, 4'd0,  3'd0, 1'b0});
    tab.push_back('{624, 273, 7'h31, 4'd5,  3'd0, 1'b1});
    tab.push_back('{632, 273, 7'h32, 4'd5,  3'd0, 1'b1});
    tab.push_back('{640, 273, 7'h33, 4'd5,  3'd0, 1'b1});
    tab.push_back('{655, 273, 7'h34, 4'd5,  3'd7, 1'b1});
    tab.push_back('{577, 283, 7'h53, 4'd15, 3'd1, 1'b1});
    tab.push_back('{576, 284, 7'h20, 4'd0,  3'd0, 1'b0});
    tab.push_back('{576, 267, 7'h20, 4'd0,  3'd0, 1'b0});
    tab.push_back('{576, 332, 7'h4C, 4'd0,  3'd0, 1'b1});
    tab.push_back('{584, 332, 7'h49, 4'd0,  3'd0, 1'b1});
    tab.push_back('{624, 332, 7'h03, 4'd0,  3'd0, 1'b1});
    tab.push_back('{640, 347, 7'h03, 4'd15, 3'd0, 1'b1});
    tab.push_back('{648, 340, 7'h20, 4'd8,  3'd0, 1'b1});
    tab.push_back('{624, 348, 7'h20, 4'd0,  3'd0, 1'b0});

    #2 rst_n = 1'b0;
    #2;
    check_out("reset_outputs", 15'd0);
    check_val("reset_busy", int'(conv_busy), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_val("idle_busy", int'(conv_busy), 0);

    do_frame(1234, 3, bc);
    check_val("busy_len_1234", bc, 15);
    foreach (tab[i]) begin
      probe(tab[i].h, tab[i].v);
      check_out($sformatf("tab%0d_h%0d_v%0d", i, tab[i].h, tab[i].v),
                {tab[i].act, tab[i].code, tab[i].line, tab[i].col});
    end

    // Saturation and zero lives
    do_frame(16383, 0, bc);
    check_val("busy_len_sat", bc, 15);
    for (int i = 6; i <= 9; i++) begin
      probe(RX + 8*i, RY);
      check_val($sformatf("sat_digit%0d", i), int'(char_code), 'h39);
    end
    for (int i = 6; i <= 15; i++) begin
      probe(RX + 8*i, RY2);
      check_val($sformatf("lives0_idx%0d", i), int'(char_code), 'h20);
    end

    // Reset five cycles into a conversion
    vblnk = 1'b0;
    score = 14'd5555;
    lives = 3'd5;
    hcount = 11'(RX);
    vcount = 11'(RY);
    step();
    vblnk = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    check_val("midreset_busy_before", int'(conv_busy), 1);
    rst_n = 1'b0;
    #1;
    check_out("midreset_outputs", 15'd0);
    check_val("midreset_busy", int'(conv_busy), 0);
    vblnk = 1'b0;
    m_score = 0;
    m_lives = 0;
    m_frames = 0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      probe(RX + 8*i, RY + 2);
      check_out($sformatf("after_reset_digit%0d", i), model(RX + 8*i, RY + 2));
    end
    do_frame(42, 2, bc);
    check_val("busy_len_42", bc, 15);
    probe(RX + 8*8, RY);
    check_val("score42_idx8", int'(char_code), 'h34);
    probe(RX + 8*9, RY);
    check_val("score42_idx9", int'(char_code), 'h32);
    scan_rows("s42");

    // Second vblnk edge during conversion with a changed score
    vblnk = 1'b0;
    score = 14'd1111;
    lives = 3'd4;
    step();
    vblnk = 1'b1;
    m_frames++;
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) vblnk = 1'b0;
      if (i == 4) score = 14'd77;
      if (i == 5) begin vblnk = 1'b1; m_frames++; end
      step();
      if (conv_busy) begin bc++; seen = 1'b1; end
      else if (seen) break;
    end
    vblnk = 1'b0;
    check_val("busy_len_reedge", bc, 15);
    m_score = 1111;
    m_lives = 4;
    scan_rows("reedge");

    // Random frames against the string model
    for (int f = 0; f < 12; f++) begin
      do_frame(int'($urandom_range(0, 16383)), int'($urandom_range(0, 7)), bc);
      check_val($sformatf("rnd%0d_busy", f), bc, 15);
      for (int k = 0; k < 40; k++) begin
        h = int'($urandom_range(RX - 8, RX + 136));
        v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(RY - 4, RY + 20))
                                        : int'($urandom_range(RY2 - 4, RY2 + 20));
        probe(h, v);
        check_out($sformatf("rnd%0d_h%0d_v%0d", f, h, v), model(h, v));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
